// File: rtl/aes_cipher_core.sv
// Iterative AES cipher core: one full round per cycle, round keys fetched by index.
// Encrypt and decrypt share the state register; S-boxes are computed combinationally.
//
// state | meaning
// IDLE  | ready for a new block, start sampled here
// INIT  | initial AddRoundKey with the first subkey
// ROUND | one full middle round per valid subkey
// FINAL | last round (no (Inv)MixColumns), loads dout
// DONE  | result held until dout_ready
module aes_cipher_core #(
  parameter int ENABLE_ENC = 1,
  parameter int ENABLE_DEC = 1,
  parameter int KEY_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [1:0]            key_len,
  input  logic [127:0]          din,
  output logic                  ready,
  output logic [KEY_ADDR_W-1:0] subkey_addr,
  input  logic [127:0]          subkey,
  input  logic                  subkey_valid,
  input  logic                  abort,
  output logic [127:0]          dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  localparam logic [KEY_ADDR_W-1:0] ONE = KEY_ADDR_W'(1);

  state_t                fsm_q, fsm_nxt;
  logic [127:0]          st_q;
  logic                  mode_q;
  logic [KEY_ADDR_W-1:0] nr_q, nr_in, addr_nxt, last_addr;
  logic                  mode_ok, start_ok;
  logic [127:0]          enc_out, dec_out, round_out;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gm(x, x);
    x3   = gm(x2, x);
    x12  = gm(gm(x3, x3), gm(x3, x3));
    x15  = gm(x12, x3);
    x240 = gm(x15, x15);
    x240 = gm(x240, x240);
    x240 = gm(x240, x240);
    x240 = gm(x240, x240);
    return gm(gm(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte index = row + 4*column, byte 0 in the top bits.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    int src;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) begin
        src = inv ? (col - row + 4) % 4 : (col + row) % 4;
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*src) -: 8];
      end
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      if (!inv) begin
        r[127-32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
        r[119-32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
        r[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
        r[103-32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end else begin
        r[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
        r[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
        r[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
        r[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
      end
    end
    return r;
  endfunction

  assign mode_ok   = mode ? (ENABLE_DEC != 0) : (ENABLE_ENC != 0);
  assign start_ok  = start && (key_len != 2'b00) && mode_ok;
  assign nr_in     = KEY_ADDR_W'(8) + KEY_ADDR_W'({key_len, 1'b0});
  assign addr_nxt  = mode_q ? subkey_addr - ONE : subkey_addr + ONE;
  assign last_addr = mode_q ? '0 : nr_q;

  always_comb begin
    enc_out = '0;
    dec_out = '0;
    if (ENABLE_ENC != 0) begin
      enc_out = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
      if (fsm_q != FINAL) enc_out = mix_cols(enc_out, 1'b0);
      enc_out = enc_out ^ subkey;
    end
    if (ENABLE_DEC != 0) begin
      dec_out = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ subkey;
      if (fsm_q != FINAL) dec_out = mix_cols(dec_out, 1'b1);
    end
    round_out = mode_q ? dec_out : enc_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_nxt;
  end

  // abort wins over subkey_valid and dout_ready in every busy state
  always_comb begin
    fsm_nxt = fsm_q;
    if (abort && fsm_q != IDLE) begin
      fsm_nxt = IDLE;
    end else begin
      case (fsm_q)
        IDLE:  if (start_ok) fsm_nxt = INIT;
        INIT:  if (subkey_valid) fsm_nxt = ROUND;
        ROUND: if (subkey_valid && addr_nxt == last_addr) fsm_nxt = FINAL;
        FINAL: if (subkey_valid) fsm_nxt = DONE;
        DONE:  if (dout_ready) fsm_nxt = IDLE;
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (fsm_q == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= '0;
      mode_q      <= 1'b0;
      nr_q        <= '0;
      subkey_addr <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= (fsm_q == IDLE) && start && !start_ok;
      if (abort && fsm_q != IDLE) begin
        dout_valid <= 1'b0;
      end else begin
        case (fsm_q)
          IDLE: if (start_ok) begin
            st_q        <= din;
            mode_q      <= mode;
            nr_q        <= nr_in;
            subkey_addr <= mode ? nr_in : '0;
          end
          INIT: if (subkey_valid) begin
            st_q        <= st_q ^ subkey;
            subkey_addr <= addr_nxt;
          end
          ROUND: if (subkey_valid) begin
            st_q        <= round_out;
            subkey_addr <= addr_nxt;
          end
          FINAL: if (subkey_valid) begin
            st_q       <= round_out;
            dout       <= round_out;
            dout_valid <= 1'b1;
          end
          DONE: if (dout_ready) dout_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
